// File: rtl/fft_pkg.sv
// Shared FFT constants and the stage-scheduler state encoding and output bundle.
package fft_pkg;
  localparam int N      = 256;
  localparam int SIZE   = 8;
  localparam int STAGES = SIZE;

  // one-hot scheduler states
  typedef enum logic [5:0] {
    S_IDLE  = 6'b000001,
    S_ACK   = 6'b000010,
    S_START = 6'b000100,
    S_WAIT  = 6'b001000,
    S_SWAP  = 6'b010000,
    S_OUT   = 6'b100000
  } sched_state_e;

  typedef struct packed {
    logic       frame_ack;
    logic       stage_start;
    logic [3:0] stage_idx;
    logic       rd_bank;
    logic       out_valid;
    logic       out_bank;
    logic       busy;
  } sched_out_t;
endpackage

// File: rtl/fft_sched_wdog.sv
// Stage watchdog: counts cycles since stage_start (the start cycle counts as one).
module fft_sched_wdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                 cnt <= '0;
    else if (clr)                               cnt <= CW'(1);
    else if (cnt_en && (cnt != CW'(LIMIT)))     cnt <= cnt + CW'(1);
  end

  // fires in the cycle whose increment would reach LIMIT
  assign expired = cnt_en && (cnt >= CW'(LIMIT - 1));
endmodule

// File: rtl/fft_stage_scheduler.sv
// Radix-2 FFT stage sequencer over a ping-pong bank pair.
// Optional stage watchdog enabled by defining FFT_SCHED_WDOG_EN.
module fft_stage_scheduler
  import fft_pkg::*;
#(
  parameter int N           = fft_pkg::N,
  parameter int SIZE        = fft_pkg::SIZE,
  parameter int WDOG_CYCLES = 4 * N
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_rdy,
  output logic       frame_ack,
  output logic       stage_start,
  output logic [3:0] stage_idx,
  input  logic       stage_done,
  output logic       rd_bank,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bank,
  output logic       busy,
  output logic       err_timeout
);
  localparam logic [3:0] LAST = 4'(SIZE - 1);

  if (((1 << SIZE) != N) || (WDOG_CYCLES < 2) || (SIZE > 16) || (SIZE < 1)) begin : g_bad_cfg
    $error("fft_stage_scheduler: need N == 2**SIZE, 1 <= SIZE <= 16, WDOG_CYCLES >= 2");
  end

  sched_state_e st, nxt;
  sched_out_t   q, d;
  logic         timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= S_IDLE;
      q  <= '0;
    end else begin
      st <= nxt;
      q  <= d;
    end
  end

  // all outputs are registered from the next-state decode
  always_comb begin
    nxt           = st;
    d             = q;
    d.frame_ack   = 1'b0;
    d.stage_start = 1'b0;
    case (st)
      S_IDLE: if (frame_rdy) begin
        nxt         = S_ACK;
        d.frame_ack = 1'b1;
        d.stage_idx = '0;
        d.rd_bank   = 1'b0;
      end
      S_ACK: begin
        nxt           = S_START;
        d.stage_start = 1'b1;
      end
      S_START: nxt = S_WAIT;
      S_WAIT: begin
        if (stage_done) begin
          if (q.stage_idx == LAST) begin
            nxt         = S_OUT;
            d.out_valid = 1'b1;
            d.out_bank  = ~q.rd_bank;
          end else begin
            nxt = S_SWAP;
          end
        end else if (timeout) begin
          nxt = S_IDLE;
        end
      end
      S_SWAP: begin
        nxt           = S_START;
        d.stage_idx   = q.stage_idx + 4'd1;
        d.rd_bank     = ~q.rd_bank;
        d.stage_start = 1'b1;
      end
      S_OUT: if (out_ready) begin
        nxt         = S_IDLE;
        d.out_valid = 1'b0;
      end
      default: nxt = S_IDLE;
    endcase
    d.busy = (nxt != S_IDLE);
  end

`ifdef FFT_SCHED_WDOG_EN
  logic wd_expired;
  logic err_q;

  fft_sched_wdog #(.LIMIT(WDOG_CYCLES)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (q.stage_start),
    .cnt_en  (st == S_WAIT),
    .expired (wd_expired)
  );

  // a stage_done in the expiry cycle still wins
  assign timeout = wd_expired && !stage_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         err_q <= 1'b0;
    else if ((st == S_WAIT) && timeout) err_q <= 1'b1;
  end

  assign err_timeout = err_q;
`else
  assign timeout     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign frame_ack   = q.frame_ack;
  assign stage_start = q.stage_start;
  assign stage_idx   = q.stage_idx;
  assign rd_bank     = q.rd_bank;
  assign out_valid   = q.out_valid;
  assign out_bank    = q.out_bank;
  assign busy        = q.busy;
endmodule

// File: tb/tb_fft_stage_scheduler.sv
// Self-checking bench for fft_stage_scheduler, N=16 (4 stages), WDOG_CYCLES=20.
module tb_fft_stage_scheduler;
  localparam int N    = 16;
  localparam int SIZE = 4;
  localparam int WD   = 20;
  localparam int LAST = SIZE - 1;
`ifdef FFT_SCHED_WDOG_EN
  localparam bit WDOG_ON = 1'b1;
`else
  localparam bit WDOG_ON = 1'b0;
`endif

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       frame_rdy = 1'b0, stage_done = 1'b0, out_ready = 1'b0;
  logic       frame_ack, stage_start, rd_bank, out_valid, out_bank, busy, err_timeout;
  logic [3:0] stage_idx;

  fft_stage_scheduler #(.N(N), .SIZE(SIZE), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .frame_rdy(frame_rdy), .frame_ack(frame_ack),
    .stage_start(stage_start), .stage_idx(stage_idx), .stage_done(stage_done),
    .rd_bank(rd_bank), .out_valid(out_valid), .out_ready(out_ready),
    .out_bank(out_bank), .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pulses and delays, expressed per cycle at negedge.
  bit m_active, m_ack, m_start, m_wait, m_valid, m_bank, m_err, m_inc;
  int m_stage, start_in, wcyc;
  bit n_active, n_ack, n_start, n_wait, n_valid, n_bank, n_err;
  int n_stage;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_active = 0; m_ack = 0; m_start = 0; m_wait = 0; m_valid = 0;
      m_bank = 0; m_err = 0; m_inc = 0; m_stage = 0; start_in = 0; wcyc = 0;
    end
    chk("m_frame_ack", frame_ack, m_ack);
    chk("m_stage_start", stage_start, m_start);
    chk("m_stage_idx", stage_idx, m_stage);
    chk("m_rd_bank", rd_bank, m_stage % 2);
    chk("m_out_valid", out_valid, m_valid);
    chk("m_out_bank", out_bank, m_bank);
    chk("m_busy", busy, m_active);
    chk("m_err_timeout", err_timeout, m_err);
    if (rst_n) begin
      n_active = m_active; n_ack = 0; n_start = 0; n_wait = m_wait;
      n_valid = m_valid; n_bank = m_bank; n_err = m_err; n_stage = m_stage;
      if (start_in > 0) begin
        start_in--;
        if (start_in == 0) begin
          n_start = 1;
          if (m_inc) n_stage = m_stage + 1;
          m_inc = 0;
        end
      end
      if (!m_active && frame_rdy) begin
        n_active = 1; n_ack = 1; n_stage = 0; start_in = 1; m_inc = 0;
      end
      if (m_start) begin
        n_wait = 1; wcyc = 1;
      end else if (m_wait) begin
        if (stage_done) begin
          n_wait = 0;
          if (m_stage == LAST) begin
            n_valid = 1; n_bank = !(m_stage % 2);
          end else begin
            start_in = 1; m_inc = 1;
          end
        end else begin
          wcyc++;
          if (WDOG_ON && wcyc == WD) begin
            n_wait = 0; n_err = 1; n_active = 0;
          end
        end
      end
      if (m_valid && out_ready) begin
        n_valid = 0; n_active = 0;
      end
      m_active = n_active; m_ack = n_ack; m_start = n_start; m_wait = n_wait;
      m_valid = n_valid; m_bank = n_bank; m_err = n_err; m_stage = n_stage;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_start(input int maxc);
    int n = 0;
    while (stage_start !== 1'b1 && n < maxc) begin tick(); n++; end
    if (stage_start !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_start timeout actual=none required=stage_start within %0d cycles", maxc);
    end
  endtask

  // entered on a stage_start cycle; returns on the next stage_start or the out_valid cycle
  task automatic do_stage(input int s, input int dly);
    chk("stage_idx_at_start", stage_idx, s);
    chk("rd_bank_at_start", rd_bank, s % 2);
    tick();
    repeat (dly) tick();
    stage_done = 1'b1; tick(); stage_done = 1'b0;
    if (s < LAST) begin
      tick();
      chk("lat_done_to_start", stage_start, 1);
    end else begin
      chk("last_out_valid", out_valid, 1);
      chk("last_out_bank", out_bank, 0);
    end
  endtask

  task automatic begin_frame();
    frame_rdy = 1'b1; tick();
    chk("frame_ack_pulse", frame_ack, 1);
    frame_rdy = 1'b0; tick();
    chk("lat_frame_to_start", stage_start, 1);
  endtask

  initial begin
    tick();
    chk("rst_frame_ack", frame_ack, 0);
    chk("rst_stage_start", stage_start, 0);
    chk("rst_stage_idx", stage_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_timeout, 0);
    tick();
    rst_n = 1'b1;
    tick(); tick();

    // frame 1: full 4-stage run then 10 cycles of backpressure
    begin_frame();
    for (int s = 0; s < SIZE; s++) do_stage(s, s + 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_bank", out_bank, 0);
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("hs_busy", busy, 0);
    chk("hs_out_valid", out_valid, 0);

    // frame 2: stage_done in START ignored, frame_rdy held while busy
    begin_frame();
    stage_done = 1'b1; tick(); stage_done = 1'b0;
    chk("spur_done_idx", stage_idx, 0);
    tick(); tick();
    chk("spur_done_no_start", stage_start, 0);
    chk("spur_done_busy", busy, 1);
    frame_rdy = 1'b1;
    stage_done = 1'b1; tick(); stage_done = 1'b0;
    tick();
    wait_start(10);
    for (int s = 1; s < SIZE; s++) do_stage(s, 2);
    chk("spur_rdy_no_ack", frame_ack, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("idle_after_hs", busy, 0);
    tick();
    chk("rdy_served_in_idle", frame_ack, 1);
    frame_rdy = 1'b0;

    // frame 3: reset during stage 2
    tick();
    wait_start(10);
    do_stage(0, 1);
    do_stage(1, 1);
    chk("pre_rst_idx", stage_idx, 2);
    tick();
    rst_n = 1'b0; #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_idx", stage_idx, 0);
    chk("mid_rst_rd_bank", rd_bank, 0);
    chk("mid_rst_stage_start", stage_start, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_bank", out_bank, 0);
    chk("mid_rst_frame_ack", frame_ack, 0);
    chk("mid_rst_err", err_timeout, 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_out_valid", out_valid, 0);

    // frame 4: normal run after reset, out_ready already high when out_valid rises
    begin_frame();
    for (int s = 0; s < SIZE; s++) begin
      if (s == LAST) out_ready = 1'b1;
      do_stage(s, 0);
    end
    tick(); out_ready = 1'b0;
    chk("same_cycle_hs", out_valid, 0);
    chk("same_cycle_hs_busy", busy, 0);

    // frame 5: stage controller never answers
    begin_frame();
    begin
      int n = 0;
      while (err_timeout !== 1'b1 && n < 40) begin tick(); n++; end
      if (WDOG_ON) begin
        chk("wdog_latency", n, WD);
        chk("wdog_idle", busy, 0);
        chk("wdog_no_valid", out_valid, 0);
        repeat (3) tick();
        chk("wdog_sticky", err_timeout, 1);
      end else begin
        chk("nowdog_err", err_timeout, 0);
        chk("nowdog_busy", busy, 1);
      end
    end
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    chk("final_err_cleared", err_timeout, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fft_stage_scheduler.md
FFT_STAGE_SCHEDULER -- requirements
Module: fft_stage_scheduler

Interface
REQ-001 Parameter N, default 256, FFT length in points (power of two).
REQ-002 Parameter SIZE, default 8, log2(N); also the number of radix-2 stages, STAGES = SIZE.
REQ-003 Parameter WDOG_CYCLES, default 4*N, maximum clk cycles allowed between stage_start and stage_done.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 frame_rdy  in  1  level request from the input loader: bank 0 holds a full frame; held high until frame_ack.
REQ-007 frame_ack  out  1  one-cycle pulse; frame accepted, loader may release bank 0.
REQ-008 stage_start  out  1  one-cycle pulse starting the stage controller.
REQ-009 stage_idx  out  4  current stage number, 0..STAGES-1.
REQ-010 stage_done  in  1  one-cycle pulse from the stage controller at stage completion.
REQ-011 rd_bank  out  1  ping-pong bank read by the stage; the stage writes bank ~rd_bank.
REQ-012 out_valid  out  1  result frame ready in out_bank; held until accepted.
REQ-013 out_ready  in  1  output unloader accepts the result.
REQ-014 out_bank  out  1  bank holding the final result.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 err_timeout  out  1  sticky watchdog error flag.

Function
REQ-017 FSM states: IDLE, ACK, START, WAIT_DONE, SWAP, OUT_HS; all outputs registered.
REQ-018 IDLE: frame_rdy=1 -> ACK; otherwise stay in IDLE.
REQ-019 ACK: frame_ack=1 for one cycle, stage_idx<=0, rd_bank<=0 -> START.
REQ-020 START: stage_start=1 for one cycle -> WAIT_DONE; frame_rdy sampled high at cycle t gives stage_start high at t+2.
REQ-021 WAIT_DONE: stage_done=1 and stage_idx==STAGES-1 -> OUT_HS, with out_bank<=~rd_bank and out_valid<=1.
REQ-022 WAIT_DONE: stage_done=1 and stage_idx<STAGES-1 -> SWAP.
REQ-023 SWAP: rd_bank toggles, stage_idx increments -> START; the next stage_start occurs exactly 2 cycles after stage_done.
REQ-024 OUT_HS: out_valid stays high and out_bank stays stable until out_ready is sampled high; then out_valid<=0 -> IDLE.
REQ-025 out_valid and out_ready high in the same cycle completes the handshake in that cycle.
REQ-026 stage_done outside WAIT_DONE is ignored.
REQ-027 frame_rdy outside IDLE is not acknowledged; it is served on the first IDLE cycle after the current frame.
REQ-028 stage_idx never exceeds STAGES-1; it wraps to 0 only via ACK.

Reset
REQ-029 rst_n low forces IDLE asynchronously.
REQ-030 During reset, every output is 0: frame_ack, stage_start, stage_idx, rd_bank, out_valid, out_bank, busy and err_timeout.
REQ-031 Reset asserted mid-frame abandons the frame; no out_valid is issued for it.

Configuration
REQ-032 Macro FFT_SCHED_WDOG_EN defined: a counter clears on stage_start and increments in WAIT_DONE.
REQ-033 With FFT_SCHED_WDOG_EN, a count reaching WDOG_CYCLES without stage_done sets err_timeout and returns the FSM to IDLE without out_valid.
REQ-034 With FFT_SCHED_WDOG_EN, err_timeout clears only on reset.
REQ-035 Macro FFT_SCHED_WDOG_EN undefined: no counter is built and err_timeout is tied to 0; the port list is identical in both builds.

Structure
REQ-036 Shared package fft_pkg holds N, SIZE, the derived STAGES constant and the scheduler state encoding (one-hot, 6 bits).
REQ-037 The watchdog is the sub-module fft_sched_wdog (clear, count-enable, expired), instantiated only under FFT_SCHED_WDOG_EN.

Verification
REQ-038 Bench case, N=16: frame_rdy held high -> frame_ack pulse; 4 stage_start pulses with stage_idx 0,1,2,3 and rd_bank 0,1,0,1; out_bank=0 with out_valid high.
REQ-039 Bench case, latency: stage_done at cycle t -> next stage_start at t+2; frame_rdy at t0 -> stage_start at t0+2.
REQ-040 Bench case, backpressure: out_ready held low 10 cycles -> out_valid and out_bank stable; out_ready=1 -> IDLE the next cycle with busy=0.
REQ-041 Bench case, spurious inputs: frame_rdy high during WAIT_DONE -> no frame_ack until IDLE; stage_done pulse in START -> no state change.
REQ-042 Bench case, watchdog (FFT_SCHED_WDOG_EN, WDOG_CYCLES=20): no stage_done -> err_timeout=1 20 cycles after stage_start, FSM in IDLE, out_valid never asserted.
REQ-043 Bench case, reset in stage 2: rst_n low -> all outputs 0 immediately; a new frame then runs normally from stage_idx 0.
